wb_regfile: RTL and testbench

//   Write-back stage and general register file of the 5-stage CPU. Consumes the
//   MEM/WB pipeline outputs, selects the write-back value and commits it to a
//   32-entry register file. Serves two combinational read ports to the ID stage
//   and keeps a counter of committed register writes for debug/perf use.

---
 rtl/wb_regfile_pkg.sv | 11 +
 rtl/wb_regfile_if.sv | 30 +++
 rtl/wb_regfile_wb_sel.sv | 13 +
 rtl/wb_regfile.sv | 58 +++++
 tb/tb_wb_regfile.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared CPU constants for the write-back stage and register file.
package wb_regfile_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO  = 5'd0;
    localparam logic [DATA_W-1:0] RESET_VAL = 32'h0;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB inputs, ID read ports and debug outputs of the write-back stage.
interface wb_regfile_if #(
    parameter int unsigned DATA_W = wb_regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W = wb_regfile_pkg::ADDR_W,
    parameter int unsigned CNT_W  = wb_regfile_pkg::CNT_W
);

    logic              WBwreg;
    logic              WBm2reg;
    logic [ADDR_W-1:0] WBwn;
    logic [DATA_W-1:0] WBaluResult;
    logic [DATA_W-1:0] WBmemOut;
    logic [ADDR_W-1:0] rna;
    logic [ADDR_W-1:0] rnb;
    logic [DATA_W-1:0] qa;
    logic [DATA_W-1:0] qb;
    logic [DATA_W-1:0] wbData;
    logic [CNT_W-1:0]  commitCount;

    modport master (
        output WBwreg, WBm2reg, WBwn, WBaluResult, WBmemOut, rna, rnb,
        input  qa, qb, wbData, commitCount
    );

    modport slave (
        input  WBwreg, WBm2reg, WBwn, WBaluResult, WBmemOut, rna, rnb,
        output qa, qb, wbData, commitCount
    );

endinterface

// File: rtl/wb_regfile_wb_sel.sv
// Write-back 2:1 mux (wb_sel): memory load data or ALU result; shared with forwarding.
module wb_regfile_wb_sel #(
    parameter int unsigned DATA_W = wb_regfile_pkg::DATA_W
) (
    input  logic              m2reg,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_out,
    output logic [DATA_W-1:0] wb_data_c
);

    assign wb_data_c = m2reg ? mem_out : alu_result;

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: 32-entry register file, two combinational read ports, commit counter.
// Optional macro REGFILE_BYPASS_EN: write-first bypass from wbData onto qa/qb.
module wb_regfile #(
    parameter int unsigned DATA_W = wb_regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W = wb_regfile_pkg::ADDR_W,
    parameter int unsigned CNT_W  = wb_regfile_pkg::CNT_W
) (
    input  logic         clk,
    input  logic         clrn,
    wb_regfile_if.slave  bus
);

    import wb_regfile_pkg::*;

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [CNT_W-1:0]  commit_count;
    logic [DATA_W-1:0] wb_data_c;
    logic              commit_c;

    wb_regfile_wb_sel #(.DATA_W(DATA_W)) u_wb_sel (
        .m2reg      (bus.WBm2reg),
        .alu_result (bus.WBaluResult),
        .mem_out    (bus.WBmemOut),
        .wb_data_c  (wb_data_c)
    );

    // r0 writes are dropped and never counted
    assign commit_c = clrn && bus.WBwreg && (bus.WBwn != ADDR_W'(REG_ZERO));

    // Register array and commit counter
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= DATA_W'(RESET_VAL);
            end
            commit_count <= '0;
        end else if (commit_c) begin
            regs[bus.WBwn] <= wb_data_c;
            commit_count   <= commit_count + CNT_W'(1);
        end
    end

    // Read ports; r0 hardwired to zero
    always_comb begin
        bus.qa = (bus.rna == ADDR_W'(REG_ZERO)) ? '0 : regs[bus.rna];
        bus.qb = (bus.rnb == ADDR_W'(REG_ZERO)) ? '0 : regs[bus.rnb];
`ifdef REGFILE_BYPASS_EN
        if (commit_c && (bus.WBwn == bus.rna)) bus.qa = wb_data_c;
        if (commit_c && (bus.WBwn == bus.rnb)) bus.qb = wb_data_c;
`endif
    end

    assign bus.wbData      = wb_data_c;
    assign bus.commitCount = commit_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile (counter narrowed to 4 bits to reach wrap quickly).
module tb_wb_regfile;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 4;

    logic clk;
    logic clrn;
    int   n_pass;
    int   n_total;
    logic [CNT_W-1:0] exp_cnt;

    wb_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one write at a negedge, let it commit at the posedge, then drop WBwreg
    task automatic do_write(input logic [ADDR_W-1:0] wn, input logic m2reg,
                            input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem);
        @(negedge clk);
        bus.WBwreg      = 1'b1;
        bus.WBm2reg     = m2reg;
        bus.WBwn        = wn;
        bus.WBaluResult = alu;
        bus.WBmemOut    = mem;
        @(posedge clk);
        #1;
        bus.WBwreg = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_total++;
        if (bus.commitCount !== 4'd0)
            $display("FAIL reset_cnt: got %0d expected 0", bus.commitCount);
        else n_pass++;
        for (int i = 0; i < 32; i++) begin
            bus.rna = 5'(i);
            bus.rnb = 5'(31 - i);
            #1;
            n_total++;
            if (bus.qa !== 32'h0 || bus.qb !== 32'h0)
                $display("FAIL reset_read[%0d]: qa=%h qb=%h expected 0", i, bus.qa, bus.qb);
            else n_pass++;
        end
        @(negedge clk);
        clrn = 1'b1;
        exp_cnt = '0;
    endtask

    task automatic test_alu_write;
        do_write(5'd5, 1'b0, 32'h00001234, 32'h0);
        exp_cnt++;
        bus.rna = 5'd5;
        #1;
        n_total++;
        if (bus.qa !== 32'h00001234)
            $display("FAIL alu_write_qa: got %h expected 00001234", bus.qa);
        else n_pass++;
        n_total++;
        if (bus.commitCount !== exp_cnt)
            $display("FAIL alu_write_cnt: got %0d expected %0d", bus.commitCount, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_load_write;
        @(negedge clk);
        bus.WBwreg      = 1'b1;
        bus.WBm2reg     = 1'b1;
        bus.WBwn        = 5'd31;
        bus.WBmemOut    = 32'hDEADBEEF;
        bus.WBaluResult = 32'h1;
        #1;
        n_total++;
        if (bus.wbData !== 32'hDEADBEEF)
            $display("FAIL load_wbdata: got %h expected deadbeef", bus.wbData);
        else n_pass++;
        @(posedge clk);
        #1;
        bus.WBwreg = 1'b0;
        exp_cnt++;
        bus.rnb = 5'd31;
        #1;
        n_total++;
        if (bus.qb !== 32'hDEADBEEF)
            $display("FAIL load_qb: got %h expected deadbeef", bus.qb);
        else n_pass++;
        bus.WBm2reg = 1'b0;
        #1;
        n_total++;
        if (bus.wbData !== 32'h1)
            $display("FAIL alu_wbdata: got %h expected 00000001", bus.wbData);
        else n_pass++;
        n_total++;
        if (bus.commitCount !== exp_cnt)
            $display("FAIL load_cnt: got %0d expected %0d", bus.commitCount, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_r0_write;
        do_write(5'd0, 1'b0, 32'hFFFFFFFF, 32'h0);
        bus.rna = 5'd0;
        #1;
        n_total++;
        if (bus.qa !== 32'h0)
            $display("FAIL r0_qa: got %h expected 0", bus.qa);
        else n_pass++;
        n_total++;
        if (bus.commitCount !== exp_cnt)
            $display("FAIL r0_cnt: got %0d expected %0d", bus.commitCount, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_bypass;
        logic [DATA_W-1:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 32'hA5A5;
`else
        exp_pre = 32'h11;
`endif
        do_write(5'd7, 1'b0, 32'h11, 32'h0);
        exp_cnt++;
        @(negedge clk);
        bus.WBwreg      = 1'b1;
        bus.WBm2reg     = 1'b0;
        bus.WBwn        = 5'd7;
        bus.WBaluResult = 32'hA5A5;
        bus.rna         = 5'd7;
        bus.rnb         = 5'd7;
        #1;
        n_total++;
        if (bus.qa !== exp_pre || bus.qb !== exp_pre)
            $display("FAIL bypass_pre: qa=%h qb=%h expected %h", bus.qa, bus.qb, exp_pre);
        else n_pass++;
        bus.rnb = 5'd5;
        #1;
        n_total++;
        if (bus.qb !== 32'h00001234)
            $display("FAIL bypass_other_port: got %h expected 00001234", bus.qb);
        else n_pass++;
        bus.rnb = 5'd7;
        @(posedge clk);
        #1;
        bus.WBwreg = 1'b0;
        exp_cnt++;
        #1;
        n_total++;
        if (bus.qa !== 32'hA5A5 || bus.qb !== 32'hA5A5)
            $display("FAIL bypass_post: qa=%h qb=%h expected 0000a5a5", bus.qa, bus.qb);
        else n_pass++;
        n_total++;
        if (bus.commitCount !== exp_cnt)
            $display("FAIL bypass_cnt: got %0d expected %0d", bus.commitCount, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_no_write;
        @(negedge clk);
        bus.WBwreg      = 1'b0;
        bus.WBwn        = 5'd5;
        bus.WBaluResult = 32'hDEAD0000;
        @(posedge clk);
        #1;
        bus.rna = 5'd5;
        #1;
        n_total++;
        if (bus.qa !== 32'h00001234 || bus.commitCount !== exp_cnt)
            $display("FAIL no_write: qa=%h cnt=%0d expected 00001234 cnt=%0d",
                     bus.qa, bus.commitCount, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_midrun;
        @(negedge clk);
        bus.WBwreg      = 1'b1;
        bus.WBm2reg     = 1'b0;
        bus.WBwn        = 5'd3;
        bus.WBaluResult = 32'h333;
        bus.rna         = 5'd5;
        bus.rnb         = 5'd3;
        clrn            = 1'b0;
        #1;
        n_total++;
        if (bus.qa !== 32'h0 || bus.qb !== 32'h0)
            $display("FAIL midrun_read: qa=%h qb=%h expected 0", bus.qa, bus.qb);
        else n_pass++;
        n_total++;
        if (bus.commitCount !== 4'd0)
            $display("FAIL midrun_cnt: got %0d expected 0", bus.commitCount);
        else n_pass++;
        n_total++;
        if (bus.wbData !== 32'h333)
            $display("FAIL midrun_wbdata: got %h expected 00000333", bus.wbData);
        else n_pass++;
        @(posedge clk);
        #1;
        @(negedge clk);
        clrn       = 1'b1;
        bus.WBwreg = 1'b0;
        exp_cnt    = '0;
        bus.rna    = 5'd3;
        bus.rnb    = 5'd31;
        @(posedge clk);
        #1;
        n_total++;
        if (bus.qa !== 32'h0 || bus.qb !== 32'h0)
            $display("FAIL midrun_lost: r3=%h r31=%h expected 0", bus.qa, bus.qb);
        else n_pass++;
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 16; i++) begin
            do_write(5'(1 + (i % 30)), 1'b0, 32'(100 + i), 32'h0);
            exp_cnt++;
            if (i == 0) begin
                n_total++;
                if (bus.commitCount !== 4'd1)
                    $display("FAIL wrap_first: got %0d expected 1", bus.commitCount);
                else n_pass++;
            end
        end
        #1;
        n_total++;
        if (bus.commitCount !== 4'd0)
            $display("FAIL wrap_16: got %0d expected 0", bus.commitCount);
        else n_pass++;
        bus.rna = 5'd16;
        #1;
        n_total++;
        if (bus.qa !== 32'd115)
            $display("FAIL wrap_r16: got %h expected %h", bus.qa, 32'd115);
        else n_pass++;
        do_write(5'd20, 1'b1, 32'h0, 32'hCAFE0017);
        exp_cnt++;
        bus.rna = 5'd20;
        #1;
        n_total++;
        if (bus.commitCount !== 4'd1)
            $display("FAIL wrap_17: got %0d expected 1", bus.commitCount);
        else n_pass++;
        n_total++;
        if (bus.qa !== 32'hCAFE0017)
            $display("FAIL wrap_r20: got %h expected cafe0017", bus.qa);
        else n_pass++;
    endtask

    initial begin
        n_pass          = 0;
        n_total         = 0;
        exp_cnt         = '0;
        clrn            = 1'b1;
        bus.WBwreg      = 1'b0;
        bus.WBm2reg     = 1'b0;
        bus.WBwn        = '0;
        bus.WBaluResult = '0;
        bus.WBmemOut    = '0;
        bus.rna         = '0;
        bus.rnb         = '0;
        #2;
        clrn = 1'b0;
        test_reset;
        test_alu_write;
        test_load_write;
        test_r0_write;
        test_bypass;
        test_no_write;
        test_reset_midrun;
        test_wrap;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
